// File: rtl/irq_dispatcher_if.sv
// Dispatcher-side bundle: encoder request inputs, core handshake, and the
// dispatched vector / status outputs.
interface irq_dispatcher_if #(
   parameter int ADDR_W = 32
);
   logic              enable;
   logic              irq_in;
   logic [1:0]        irq_id;
   logic              cpu_ack;
   logic              cpu_eoi;
   logic              int_req;
   logic [ADDR_W-1:0] int_vec;
   logic [1:0]        int_id;
   logic [3:0]        in_service;
   logic              busy;
   logic [15:0]       ack_latency;

   modport master (
      input  enable, irq_in, irq_id, cpu_ack, cpu_eoi,
      output int_req, int_vec, int_id, in_service, busy, ack_latency
   );

   modport slave (
      output enable, irq_in, irq_id, cpu_ack, cpu_eoi,
      input  int_req, int_vec, int_id, in_service, busy, ack_latency
   );
endinterface

// File: rtl/irq_dispatcher.sv
// Captures one encoded interrupt at a time, hands it to the core as a vectored
// req/ack request, and blocks further captures until end-of-interrupt.
//
// state   | meaning
// IDLE    | no interrupt pending; capture on enable && irq_in
// REQ     | int_req raised, waiting for cpu_ack; latency counter running
// SERVICE | core running the handler; waiting for cpu_eoi
module irq_dispatcher #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
   parameter int unsigned       VEC_STRIDE = 16
) (
   input  logic             clk,
   input  logic             rst,
   irq_dispatcher_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t            state, state_nxt;
   logic              capture, ack_take, eoi_take;
   logic [ADDR_W-1:0] vec_nxt;
   logic [1:0]        id_q;
   logic [ADDR_W-1:0] vec_q;
   logic [3:0]        in_service_q;
   logic [15:0]       lat_cnt;
   logic [15:0]       ack_lat_q;

   assign vec_nxt = VEC_BASE + ADDR_W'(bus.irq_id) * ADDR_W'(VEC_STRIDE);

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      ack_take  = 1'b0;
      eoi_take  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.enable && bus.irq_in) begin
               capture   = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            // ack wins over a simultaneous eoi; the eoi must come again in SERVICE
            if (bus.cpu_ack) begin
               ack_take  = 1'b1;
               state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            if (bus.cpu_eoi) begin
               eoi_take  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         id_q         <= '0;
         vec_q        <= '0;
         in_service_q <= '0;
         lat_cnt      <= '0;
         ack_lat_q    <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            id_q    <= bus.irq_id;
            vec_q   <= vec_nxt;
            lat_cnt <= 16'd1;
         end
         if (state == REQ && !bus.cpu_ack && lat_cnt != 16'hFFFF)
            lat_cnt <= lat_cnt + 16'd1;
         if (ack_take) begin
            in_service_q <= 4'(1) << id_q;
            ack_lat_q    <= lat_cnt;
         end
         if (eoi_take)
            in_service_q <= '0;
      end
   end

   assign bus.int_req     = (state == REQ);
   assign bus.busy        = (state != IDLE);
   assign bus.int_id      = id_q;
   assign bus.int_vec     = vec_q;
   assign bus.in_service  = in_service_q;
   assign bus.ack_latency = ack_lat_q;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Table-driven bench for irq_dispatcher: each row is one clock of stimulus
// with the outputs expected after that edge, routed through a scoreboard queue.
module tb_irq_dispatcher;

   logic clk = 1'b0;
   logic rst = 1'b1;

   irq_dispatcher_if #(.ADDR_W(32)) bus ();

   irq_dispatcher #(
      .ADDR_W    (32),
      .VEC_BASE  (32'h0000_0100),
      .VEC_STRIDE(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        enable;
      logic        irq_in;
      logic [1:0]  irq_id;
      logic        ack;
      logic        eoi;
      logic        req;
      logic        busy;
      logic [1:0]  id;
      logic [31:0] vec;
      logic [3:0]  insvc;
      logic [15:0] lat;
      string       name;
   } vec_t;

   typedef struct {
      logic        req;
      logic        busy;
      logic [1:0]  id;
      logic [31:0] vec;
      logic [3:0]  insvc;
      logic [15:0] lat;
      string       name;
   } exp_t;

   localparam int NVEC = 26;

   vec_t tbl [NVEC];
   exp_t exp_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(logic r, logic en, logic irq, logic [1:0] iid,
                               logic ack, logic eoi, logic req, logic bsy,
                               logic [1:0] id, logic [31:0] vec, logic [3:0] insvc,
                               logic [15:0] lat, string nm);
      vec_t v;
      v.rst = r; v.enable = en; v.irq_in = irq; v.irq_id = iid;
      v.ack = ack; v.eoi = eoi; v.req = req; v.busy = bsy; v.id = id;
      v.vec = vec; v.insvc = insvc; v.lat = lat; v.name = nm;
      return v;
   endfunction

   task automatic chk(string nm, string field, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
      end
   endtask

   task automatic step(vec_t v);
      exp_t e;
      rst         = v.rst;
      bus.enable  = v.enable;
      bus.irq_in  = v.irq_in;
      bus.irq_id  = v.irq_id;
      bus.cpu_ack = v.ack;
      bus.cpu_eoi = v.eoi;
      e.req = v.req; e.busy = v.busy; e.id = v.id; e.vec = v.vec;
      e.insvc = v.insvc; e.lat = v.lat; e.name = v.name;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk(e.name, "int_req",     32'(bus.int_req),     32'(e.req));
      chk(e.name, "busy",        32'(bus.busy),        32'(e.busy));
      chk(e.name, "int_id",      32'(bus.int_id),      32'(e.id));
      chk(e.name, "int_vec",     bus.int_vec,          e.vec);
      chk(e.name, "in_service",  32'(bus.in_service),  32'(e.insvc));
      chk(e.name, "ack_latency", 32'(bus.ack_latency), 32'(e.lat));
   endtask

   initial begin
      //            rst en irq id ack eoi | req bsy id vec            insvc    lat
      tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 4'b0000, 16'd0, "reset");
      tbl[1]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 4'b0000, 16'd0, "idle1");
      tbl[2]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 4'b0000, 16'd0, "idle2");
      tbl[3]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 4'b0000, 16'd0, "idle3");
      tbl[4]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 4'b0000, 16'd0, "idle4");
      tbl[5]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 4'b0000, 16'd0, "idle5");
      tbl[6]  = mk(0, 1, 1, 2, 0, 0,  1, 1, 2, 32'h0000_0120, 4'b0000, 16'd0, "cap_id2");
      tbl[7]  = mk(0, 1, 0, 0, 0, 0,  1, 1, 2, 32'h0000_0120, 4'b0000, 16'd0, "req_wait1");
      tbl[8]  = mk(0, 1, 0, 0, 0, 0,  1, 1, 2, 32'h0000_0120, 4'b0000, 16'd0, "req_wait2");
      tbl[9]  = mk(0, 1, 0, 0, 1, 0,  0, 1, 2, 32'h0000_0120, 4'b0100, 16'd3, "ack_3rd");
      tbl[10] = mk(0, 1, 1, 0, 0, 0,  0, 1, 2, 32'h0000_0120, 4'b0100, 16'd3, "svc_holdoff");
      tbl[11] = mk(0, 1, 1, 0, 1, 0,  0, 1, 2, 32'h0000_0120, 4'b0100, 16'd3, "svc_stray_ack");
      tbl[12] = mk(0, 1, 1, 0, 0, 1,  0, 0, 2, 32'h0000_0120, 4'b0000, 16'd3, "eoi");
      tbl[13] = mk(0, 1, 1, 0, 0, 0,  1, 1, 0, 32'h0000_0100, 4'b0000, 16'd3, "cap_id0");
      tbl[14] = mk(0, 1, 0, 0, 1, 1,  0, 1, 0, 32'h0000_0100, 4'b0001, 16'd1, "ack_eoi_same");
      tbl[15] = mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 32'h0000_0100, 4'b0000, 16'd1, "eoi_reissued");
      tbl[16] = mk(0, 0, 1, 3, 0, 0,  0, 0, 0, 32'h0000_0100, 4'b0000, 16'd1, "disabled");
      tbl[17] = mk(0, 0, 1, 3, 1, 1,  0, 0, 0, 32'h0000_0100, 4'b0000, 16'd1, "idle_stray");
      tbl[18] = mk(0, 1, 1, 3, 0, 0,  1, 1, 3, 32'h0000_0130, 4'b0000, 16'd1, "cap_id3");
      tbl[19] = mk(0, 0, 0, 1, 0, 0,  1, 1, 3, 32'h0000_0130, 4'b0000, 16'd1, "req_src_drop1");
      tbl[20] = mk(0, 0, 0, 1, 0, 0,  1, 1, 3, 32'h0000_0130, 4'b0000, 16'd1, "req_src_drop2");
      tbl[21] = mk(0, 0, 0, 1, 1, 0,  0, 1, 3, 32'h0000_0130, 4'b1000, 16'd3, "ack_id3");
      tbl[22] = mk(1, 1, 1, 1, 0, 0,  0, 0, 0, 32'h0000_0000, 4'b0000, 16'd0, "rst_in_svc");
      tbl[23] = mk(0, 1, 1, 1, 0, 0,  1, 1, 1, 32'h0000_0110, 4'b0000, 16'd0, "cap_id1");
      tbl[24] = mk(0, 1, 0, 0, 0, 1,  1, 1, 1, 32'h0000_0110, 4'b0000, 16'd0, "req_eoi_only");
      tbl[25] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0000_0000, 4'b0000, 16'd0, "rst_in_req");

      bus.enable = 1'b0; bus.irq_in = 1'b0; bus.irq_id = 2'd0;
      bus.cpu_ack = 1'b0; bus.cpu_eoi = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++)
         step(tbl[i]);

      // Saturation: hold REQ for 70000 cycles without ack.
      step(mk(0, 1, 1, 1, 0, 0, 1, 1, 1, 32'h0000_0110, 4'b0000, 16'd0, "sat_cap"));
      bus.irq_in = 1'b0;
      for (int c = 0; c < 70000; c++) begin
         @(posedge clk);
         #1;
      end
      step(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 32'h0000_0110, 4'b0000, 16'd0, "sat_still_req"));
      step(mk(0, 1, 0, 0, 1, 0, 0, 1, 1, 32'h0000_0110, 4'b0010, 16'hFFFF, "sat_ack"));
      step(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0110, 4'b0000, 16'hFFFF, "sat_eoi"));

      // Short wait followed by ack checks the counter restarts after saturation.
      step(mk(0, 1, 1, 2, 0, 0, 1, 1, 2, 32'h0000_0120, 4'b0000, 16'hFFFF, "recap_id2"));
      step(mk(0, 1, 0, 0, 1, 0, 0, 1, 2, 32'h0000_0120, 4'b0100, 16'd1, "ack_first"));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_dispatcher.md
# irq_dispatcher

Downstream stage of the interrupt priority encoder. Takes the encoder's registered `IRQ` and 2-bit `y` outputs and captures one request at a time. It presents the request to the CPU core as a vectored interrupt with a req/ack handshake, then holds off further requests until the core signals end-of-interrupt. It also reports per-interrupt in-service status and the request-to-acknowledge latency for each dispatched interrupt.

## Interface
Parameters:
- `ADDR_W`, 32, width of the vector address.
- `VEC_BASE`, 32'h0000_0100, address of the handler for interrupt ID 0.
- `VEC_STRIDE`, 16, byte spacing between handler entries.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  global interrupt enable; gates new captures only.
- `irq_in`  in  1  encoder `IRQ`: at least one interrupt line is active.
- `irq_id`  in  2  encoder `y`: highest-priority active ID, with 0 the highest priority.
- `cpu_ack`  in  1  core accepted the request.
- `cpu_eoi`  in  1  core finished the handler (return-from-interrupt).
- `int_req`  out  1  interrupt request to the core.
- `int_vec`  out  ADDR_W  handler address; valid while `int_req`=1.
- `int_id`  out  2  captured ID; held from capture until EOI.
- `in_service`  out  4  one-hot bit for the ID being serviced; 0 when none.
- `busy`  out  1  high in REQ or SERVICE.
- `ack_latency`  out  16  request-to-acknowledge cycles of the last acked interrupt.

## Operation
- FSM states: IDLE, REQ, SERVICE. Reset puts the FSM in IDLE.
- IDLE:
  - If `enable`=1 and `irq_in`=1: capture `irq_id` into `int_id`, load `int_vec`, and go to REQ.
  - Otherwise stay in IDLE. `cpu_ack` and `cpu_eoi` are ignored.
- REQ:
  - `int_req`=1.
  - `irq_in`, `irq_id` and `enable` are ignored. The captured request persists even if the source drops or `enable` falls.
  - On `cpu_ack`=1: go to SERVICE, set `in_service[int_id]`, and load `ack_latency`.
  - `cpu_eoi` in REQ without `cpu_ack` is ignored.
- SERVICE:
  - `int_req`=0 and `in_service` is one-hot.
  - New interrupts are held off; there is no nesting.
  - On `cpu_eoi`=1: go to IDLE and clear `in_service`. `int_id` and `int_vec` keep their values.
  - `cpu_ack` in SERVICE is ignored.
- Vector arithmetic: `int_vec` = `VEC_BASE` + `int_id`*`VEC_STRIDE`, computed at ADDR_W bits and truncated modulo 2^ADDR_W. It is registered at capture.
- Latency counter (16 bits):
  - Set to 1 on entry to REQ.
  - Increments each REQ cycle in which `cpu_ack`=0.
  - Saturates at 16'hFFFF and never wraps.
  - On ack, `ack_latency` takes the counter value, so an ack on the first REQ cycle gives 1.
- `cpu_ack` and `cpu_eoi` high in the same REQ cycle: only the ack is honoured, giving REQ→SERVICE. The EOI must be reissued.
- Reset mid-operation (any state): return to IDLE. A pending request and any in-service status are discarded without an ack or EOI.

## Timing
- Reset values: `int_req`=0, `int_vec`=0, `int_id`=0, `in_service`=0, `busy`=0, `ack_latency`=0, FSM=IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- Capture: if `irq_in`=1 at edge N (IDLE, `enable`=1), then `int_req`, `int_vec`, `int_id` and `busy` are valid after edge N.
- Ack: if `cpu_ack`=1 at edge M (REQ), then after edge M: `int_req`=0, `in_service` is set, and `ack_latency` is updated.
- EOI: if `cpu_eoi`=1 at edge K (SERVICE), then after edge K: `in_service`=0 and `busy`=0.
  - The earliest next capture is at edge K+1, so there is at least one IDLE cycle between interrupts.
- Encoder latency of one cycle is upstream. A raw line asserted before edge E reaches `int_req` after edge E+1.

## Test plan
- Reset, then `irq_in`=0 for 5 cycles → `int_req`=0, `busy`=0, `in_service`=4'b0000, `ack_latency`=0.
- `irq_in`=1, `irq_id`=2, `enable`=1 → next cycle `int_req`=1, `int_vec`=32'h0000_0120. With `cpu_ack` on the 3rd REQ cycle: `ack_latency`=3, `in_service`=4'b0100.
- While in SERVICE with ID 2, `irq_id`=0 and `irq_in`=1 → no new `int_req` until after `cpu_eoi`. After one IDLE cycle, capture ID 0 with `int_vec`=32'h0000_0100.
- `enable`=0 with `irq_in`=1 → no capture. Setting `enable`=1 → capture the next cycle. Dropping `irq_in` and `enable` in REQ → `int_req` stays 1 until ack.
- `cpu_ack` and `cpu_eoi` high together in REQ → SERVICE entered and `busy` stays 1. A stray `cpu_eoi`/`cpu_ack` in IDLE → no state change.
- No ack for 70000 cycles, then ack → `ack_latency`=16'hFFFF. Assert `rst` mid-SERVICE → all outputs return to reset values the next cycle.
